mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Multi-cycle arbiter and sequencer for the CPU's single RAM port, sharing it between the instruction-fetch path and the LDR/STR data path. It accepts level-held requests from both sides and grants one at a time, data first, with a starvation guard for fetch. It drives the RAM address, write data, RW and request lines, waits for the RAM ready handshake, and returns read data with a one-cycle done pulse. A timeout aborts hung accesses with an error flag.

## Interface
- MAX_DATA_RUN, 4: maximum consecutive data grants while FetchReq is pending; the next grant then goes to fetch. Minimum 1.
- TIMEOUT, 16: number of MemReq cycles without MemReady before the access is aborted. Minimum 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- FetchReq  input  1  fetch request, held high until FetchDone.
- FetchAddr  input  32  fetch address, sampled at grant.
- FetchDone  output  1  one-cycle pulse: fetch access complete.
- FetchData  output  32  fetched word, valid while FetchDone=1.
- DataReq  input  1  LDR/STR request, held high until DataDone.
- DataRW  input  1  0 = read (LDR), 1 = write (STR); sampled at grant.
- DataAddr  input  32  data address, sampled at grant.
- DataWData  input  32  store data, sampled at grant.
- DataDone  output  1  one-cycle pulse: data access complete.
- DataRData  output  32  load data, valid while DataDone=1.
- BusError  output  1  high with a Done pulse when that access timed out.
- AddressBus  output  32  RAM address.
- WriteDataBus  output  32  RAM write data.
- DataBusOE  output  1  high while a write is on the bus.
- ReadDataBus  input  32  RAM read data.
- RW  output  1  0 = read, 1 = write.
- MemReq  output  1  RAM access strobe.
- MemReady  input  1  RAM completion, sampled only while MemReq=1.
- Busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, FETCH_ACC, DATA_ACC, DONE.
- IDLE: if DataReq and (FetchReq=0 or run count < MAX_DATA_RUN), grant data. Otherwise, if FetchReq, grant fetch. Otherwise stay in IDLE.
- Grant: register the address, RW (fetch forces RW=0) and write data; go to FETCH_ACC or DATA_ACC.
- Run count: increments on each data grant made while FetchReq=1. Clears on a fetch grant, or when a data grant is made with FetchReq=0. Saturates at MAX_DATA_RUN.
- *_ACC: MemReq=1 and the bus is driven from the registers; DataBusOE=RW.
  - MemReady=1: capture ReadDataBus (reads only) and go to DONE.
  - Timeout counter reaches TIMEOUT-1 with MemReady still 0: set the error flag and go to DONE.
- DONE: pulse the granted requester's Done for one cycle.
  - Read data goes out on FetchData or DataRData; BusError reflects the error flag.
  - Timed-out reads return 32'h0.
  - Stores return DataRData=0.
  - Next state is IDLE.
- Requests that drop before Done are protocol violations. The granted access still completes.
- The non-granted requester waits; its request is re-evaluated in IDLE.
- Both requests arriving together: data wins, subject to the run-count guard.

## Timing
- Reset values: all outputs 0, state IDLE, run and timeout counters 0. AddressBus and WriteDataBus hold 0 until the first grant.
- Reset mid-access: MemReq drops immediately (asynchronously). No Done is issued; the requester must re-request.
- Request seen in IDLE at cycle N: MemReq=1 from cycle N+1.
- MemReady high at cycle M: Done at M+1, MemReq=0 at M+1, IDLE at M+2.
- Zero-wait RAM: Done at N+2, next grant evaluated at N+3. One access per 3 cycles.
- Timeout: MemReq is high for exactly TIMEOUT cycles. Done with BusError=1 follows on the next cycle.
- Bus outputs are stable for the whole of *_ACC. WriteDataBus is zero whenever DataBusOE=0.
- At most one of FetchDone and DataDone is high in any cycle.

## Test plan
- Single LDR: DataReq=1, DataRW=0, DataAddr=0x40, RAM returns 0xDEADBEEF with MemReady on the first MemReq cycle. Required: MemReq high for 1 cycle, DataDone 2 cycles after the request with DataRData=0xDEADBEEF, BusError=0.
- STR with 3 wait states: DataRW=1, DataAddr=0x80, DataWData=0x12345678. Required: RW=1, DataBusOE=1, AddressBus=0x80 and WriteDataBus=0x12345678 stable for 4 MemReq cycles; DataDone 1 cycle after MemReady.
- Simultaneous requests: FetchReq and DataReq raised in the same cycle. Required: data is served first, then fetch; FetchDone follows DataDone by 3 cycles with zero-wait RAM.
- Starvation guard: DataReq held high continuously with FetchReq=1 and MAX_DATA_RUN=4. Required: exactly 4 data accesses, then 1 fetch, then data again.
- Timeout: MemReady never asserted, TIMEOUT=16, fetch request. Required: MemReq high for exactly 16 cycles, then FetchDone=1 with BusError=1 and FetchData=0; the next access proceeds normally.
- Reset mid-access: rst_n driven low during DATA_ACC. Required: MemReq=0 immediately, no Done pulse, Busy=0; after release, a new request is serviced normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the RAM-port arbiter, its two requesters and the RAM.
// The master view belongs to the arbiter; the slave view belongs to the
// environment, meaning the requesters and the RAM.
interface mem_bus_arbiter_if;
  logic        FetchReq;
  logic [31:0] FetchAddr;
  logic        FetchDone;
  logic [31:0] FetchData;
  logic        DataReq;
  logic        DataRW;
  logic [31:0] DataAddr;
  logic [31:0] DataWData;
  logic        DataDone;
  logic [31:0] DataRData;
  logic        BusError;
  logic [31:0] AddressBus;
  logic [31:0] WriteDataBus;
  logic        DataBusOE;
  logic [31:0] ReadDataBus;
  logic        RW;
  logic        MemReq;
  logic        MemReady;
  logic        Busy;

  modport master (
    input  FetchReq, FetchAddr, DataReq, DataRW, DataAddr, DataWData,
           ReadDataBus, MemReady,
    output FetchDone, FetchData, DataDone, DataRData, BusError,
           AddressBus, WriteDataBus, DataBusOE, RW, MemReq, Busy
  );

  modport slave (
    output FetchReq, FetchAddr, DataReq, DataRW, DataAddr, DataWData,
           ReadDataBus, MemReady,
    input  FetchDone, FetchData, DataDone, DataRData, BusError,
           AddressBus, WriteDataBus, DataBusOE, RW, MemReq, Busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbiter and sequencer for the single RAM port. It is shared between
// instruction fetch and LDR/STR. Data normally has priority. After
// MAX_DATA_RUN back-to-back data grants made while fetch was waiting, the
// next grant goes to fetch. Each access runs IDLE -> *_ACC -> DONE. An access
// that sees no MemReady for TIMEOUT cycles is aborted and reports BusError.
module mem_bus_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.master bus
);
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH_ACC, DATA_ACC, DONE} state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             grant_data;
  logic             grant_fetch;
  logic             acc_end;

  // Arbitration decision. Data wins unless fetch is waiting and has already
  // been passed over MAX_DATA_RUN times in a row.
  assign grant_data  = bus.DataReq && (!bus.FetchReq || (run_cnt < RUN_MAX));
  assign grant_fetch = !grant_data && bus.FetchReq;
  // The access ends on a RAM handshake or when the timeout window closes.
  assign acc_end     = bus.MemReady || (to_cnt == TO_LAST);

  // Access sequencer. The bus and result outputs are registered here. An
  // asynchronous reset drops MemReq at once and discards any access that is
  // in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      run_cnt          <= '0;
      to_cnt           <= '0;
      bus.FetchDone    <= 1'b0;
      bus.FetchData    <= '0;
      bus.DataDone     <= 1'b0;
      bus.DataRData    <= '0;
      bus.BusError     <= 1'b0;
      bus.AddressBus   <= '0;
      bus.WriteDataBus <= '0;
      bus.DataBusOE    <= 1'b0;
      bus.RW           <= 1'b0;
      bus.MemReq       <= 1'b0;
      bus.Busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data || grant_fetch) begin
            bus.AddressBus   <= grant_data ? bus.DataAddr : bus.FetchAddr;
            bus.RW           <= grant_data && bus.DataRW;
            bus.DataBusOE    <= grant_data && bus.DataRW;
            bus.WriteDataBus <= (grant_data && bus.DataRW) ? bus.DataWData : '0;
            bus.MemReq       <= 1'b1;
            bus.Busy         <= 1'b1;
            to_cnt           <= '0;
            state            <= grant_data ? DATA_ACC : FETCH_ACC;
            // Count only data grants that made a waiting fetch wait longer.
            if (grant_fetch || !bus.FetchReq)
              run_cnt <= '0;
            else if (run_cnt < RUN_MAX)
              run_cnt <= run_cnt + RUN_W'(1);
          end
        end
        FETCH_ACC, DATA_ACC: begin
          if (acc_end) begin
            bus.MemReq       <= 1'b0;
            bus.DataBusOE    <= 1'b0;
            bus.WriteDataBus <= '0;
            bus.RW           <= 1'b0;
            bus.BusError     <= !bus.MemReady;
            if (state == FETCH_ACC) begin
              bus.FetchDone <= 1'b1;
              bus.FetchData <= bus.MemReady ? bus.ReadDataBus : '0;
            end else begin
              bus.DataDone  <= 1'b1;
              // Stores and timed-out loads return zero.
              bus.DataRData <= (bus.MemReady && !bus.RW) ? bus.ReadDataBus : '0;
            end
            state <= DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DONE: begin
          bus.FetchDone <= 1'b0;
          bus.FetchData <= '0;
          bus.DataDone  <= 1'b0;
          bus.DataRData <= '0;
          bus.BusError  <= 1'b0;
          bus.Busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
